// File: rtl/ipq_fetch_v35.sv
// V35 prefetch queue consumer: serves 1-4 byte fetches from the 8-entry IPQ.
// Owns the queue head pointer and the branch restart strobe.
module ipq_fetch_v35 (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ce_1,
  input  logic [7:0]  ipq [8],
  input  logic [3:0]  ipq_len,
  output logic [15:0] ipq_head,
  output logic        pfp_set,
  input  logic        fetch_req,
  input  logic [2:0]  fetch_len,
  input  logic        fetch_first,
  output logic [31:0] fetch_data,
  output logic        fetch_valid,
  output logic [15:0] instr_ip,
  input  logic        jump_req,
  input  logic [15:0] jump_addr,
  output logic        implementation_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  len_q, len_d;
  logic        first_q, first_d;
  logic        pend_q, pend_d;
  logic [15:0] head_q, head_d;
  logic        pfp_q, pfp_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] iip_q, iip_d;
  logic        fault_q, fault_d;

  logic [2:0]  req_len;
  logic        req_first;
  logic        legal;
  logic        avail;
  logic        check;
  logic [31:0] gather;

  // In IDLE the live request is evaluated; otherwise the latched one.
  always_comb begin
    req_len   = (state_q == S_IDLE) ? fetch_len : len_q;
    req_first = (state_q == S_IDLE) ? fetch_first : first_q;
    legal     = (fetch_len != 3'd0) && (fetch_len <= 3'd4);
    avail     = ipq_len >= {1'b0, req_len};
  end

  always_comb begin
    logic [2:0] idx;
    gather = 32'h0;
    for (int i = 0; i < 4; i++) begin
      idx = head_q[2:0] + 3'(i);
      if (3'(i) < req_len)
        gather[8*i +: 8] = ipq[idx];
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    first_d = first_q;
    pend_d  = pend_q;
    head_d  = head_q;
    pfp_d   = pfp_q;
    data_d  = data_q;
    valid_d = 1'b0;
    iip_d   = iip_q;
    fault_d = fault_q;
    check   = 1'b0;
    if (ce_1) begin
      if (jump_req) begin
        head_d  = jump_addr;
        pfp_d   = 1'b1;
        state_d = S_JUMP;
        if (state_q == S_IDLE && fetch_req) begin
          if (legal) begin
            len_d   = fetch_len;
            first_d = fetch_first;
            pend_d  = 1'b1;
          end else begin
            fault_d = 1'b1;
          end
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (fetch_req) begin
              if (!legal) begin
                fault_d = 1'b1;
              end else begin
                len_d   = fetch_len;
                first_d = fetch_first;
                pend_d  = 1'b1;
                check   = 1'b1;
              end
            end
          end
          S_WAIT: check = 1'b1;
          S_JUMP: begin
            pfp_d   = 1'b0;
            state_d = pend_q ? S_WAIT : S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      if (check) begin
        if (avail) begin
          data_d  = gather;
          head_d  = head_q + {13'h0, req_len};
          valid_d = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
          if (req_first)
            iip_d = head_q;
        end else begin
          state_d = S_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      len_q   <= 3'd0;
      first_q <= 1'b0;
      pend_q  <= 1'b0;
      head_q  <= 16'h0;
      pfp_q   <= 1'b0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      iip_q   <= 16'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      pfp_q   <= pfp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      iip_q   <= iip_d;
      fault_q <= fault_d;
    end
  end

  assign ipq_head             = head_q;
  assign pfp_set              = pfp_q;
  assign fetch_data           = data_q;
  assign fetch_valid          = valid_q;
  assign instr_ip             = iip_q;
  assign implementation_fault = fault_q;

endmodule
